// File: rtl/arithmetic_unit_pkg.sv
// Shared width default for the arithmetic unit slice.
package arithmetic_unit_pkg;

   // Operand width used when the top is instantiated without an override.
   localparam int unsigned AU_DEFAULT_W = 4;

endpackage : arithmetic_unit_pkg

// File: rtl/arithmetic_divider.sv
// Combinational W-bit unsigned restoring divider; b == 0 yields quot = all ones, rem = dividend.
import arithmetic_unit_pkg::*;

module arithmetic_divider #(
   parameter int unsigned W = AU_DEFAULT_W
) (
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem
);

   logic [W:0]   part;
   logic [W-1:0] qbits;

   // W-step restoring array: shift in one dividend bit, subtract divisor when it fits.
   always_comb begin
      part  = '0;
      qbits = '0;
      for (int unsigned i = 0; i < W; i++) begin
         part = {part[W-1:0], dividend[W-1-i]};
         if (part >= {1'b0, divisor}) begin
            part           = part - {1'b0, divisor};
            qbits[W-1-i]   = 1'b1;
         end
      end
      if (divisor == '0) begin
         quot = '1;
         rem  = dividend;
      end else begin
         quot = qbits;
         rem  = part[W-1:0];
      end
   end

endmodule : arithmetic_divider

// File: rtl/arithmetic_unit.sv
// Registered unsigned arithmetic unit: sum, product, difference, quotient, remainder.
import arithmetic_unit_pkg::*;

module arithmetic_unit #(
   parameter int unsigned W = AU_DEFAULT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [W:0]       sum,
   output logic [2*W-1:0]   prod,
   output logic [W-1:0]     diff,
   output logic [W-1:0]     rem,
   output logic [W-1:0]     quot
);

   logic [W:0]     sum_d;
   logic [2*W-1:0] prod_d;
   logic [W-1:0]   diff_d;
   logic [W-1:0]   quot_d;
   logic [W-1:0]   rem_d;

   arithmetic_divider #(
      .W (W)
   ) u_div (
      .dividend (a),
      .divisor  (b),
      .quot     (quot_d),
      .rem      (rem_d)
   );

   // Next-state results; operands widened so carry and full product are kept.
   always_comb begin
      sum_d  = {1'b0, a} + {1'b0, b};
      prod_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      diff_d = a - b;
   end

   // Result register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         prod <= '0;
         diff <= '0;
         quot <= '0;
         rem  <= '0;
      end else begin
         sum  <= sum_d;
         prod <= prod_d;
         diff <= diff_d;
         quot <= quot_d;
         rem  <= rem_d;
      end
   end

endmodule : arithmetic_unit

// File: tb/tb_arithmetic_unit.sv
// Directed and exhaustive self-checking bench for arithmetic_unit.
module tb_arithmetic_unit;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [W:0]     sum;
   logic [2*W-1:0] prod;
   logic [W-1:0]   diff;
   logic [W-1:0]   rem;
   logic [W-1:0]   quot;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   arithmetic_unit #(
      .W (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .prod  (prod),
      .diff  (diff),
      .rem   (rem),
      .quot  (quot)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int es, input int ep,
                            input int ed, input int eq, input int er);
      check({tag, ".sum"},  8'(sum),  8'(es));
      check({tag, ".prod"}, prod,     8'(ep));
      check({tag, ".diff"}, 8'(diff), 8'(ed));
      check({tag, ".quot"}, 8'(quot), 8'(eq));
      check({tag, ".rem"},  8'(rem),  8'(er));
   endtask

   // Drive operands away from the edge, then check one cycle later.
   task automatic vec(input string tag, input int va, input int vb, input int es,
                      input int ep, input int ed, input int eq, input int er);
      @(negedge clk);
      a = W'(va);
      b = W'(vb);
      @(posedge clk);
      #1;
      check_all(tag, es, ep, ed, eq, er);
   endtask

   initial begin
      int ps, pp, pd, pq, pr;
      int es, ep, ed, eq, er;

      rst_n = 1'b0;
      a     = 4'd12;
      b     = 4'd5;

      // Reset held across several edges.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset_hold", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1;
      check_all("reset_release_noedge", 0, 0, 0, 0, 0);

      // First capture on the edge after release.
      @(posedge clk);
      #1;
      check_all("v12_5", 17, 60, 7, 2, 2);

      vec("v3_3",   3,  3,  6,   9,  0,  1, 0);
      vec("v0_1",   0,  1,  1,   0, 15,  0, 0);
      vec("v9_0",   9,  0,  9,   0,  9, 15, 9);
      vec("v15_15", 15, 15, 30, 225, 0,  1, 0);

      // Mid-cycle reset clears without a clock edge.
      @(negedge clk);
      a = 4'd12;
      b = 4'd5;
      @(posedge clk);
      #1;
      check_all("pre_midreset", 17, 60, 7, 2, 2);
      #1;
      rst_n = 1'b0;
      #1;
      check_all("midreset", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("midreset_edge", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      vec("v15_15b", 15, 15, 30, 225, 0, 1, 0);
      ps = 30; pp = 225; pd = 0; pq = 1; pr = 0;

      // Exhaustive sweep with latency check before each capture edge.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            es = ia + ib;
            ep = ia * ib;
            ed = (ia - ib + 16) % 16;
            if (ib == 0) begin
               eq = 15;
               er = ia;
            end else begin
               eq = ia / ib;
               er = ia % ib;
            end
            @(negedge clk);
            a = W'(ia);
            b = W'(ib);
            #1;
            check("sweep_hold.sum",  8'(sum),  8'(ps));
            check("sweep_hold.quot", 8'(quot), 8'(pq));
            @(posedge clk);
            #1;
            check_all($sformatf("sweep_%0d_%0d", ia, ib), es, ep, ed, eq, er);
            ps = es; pp = ep; pd = ed; pq = eq; pr = er;
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_arithmetic_unit
